// File: rtl/ps2_receiver_if.sv
// ps2_receiver_if: raw PS/2 lines in, scan-code byte and strobes out
interface ps2_receiver_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] ps2_data;
  logic       ps2_data_clk;
  logic       ps2_error;
  modport master (output PS2_CLK, PS2_DAT, input ps2_data, ps2_data_clk, ps2_error);
  modport slave (input PS2_CLK, PS2_DAT, output ps2_data, ps2_data_clk, ps2_error);
endinterface

// File: rtl/ps2_receiver.sv
// ps2_receiver: filtered PS/2 device-to-host frame deserializer with parity/stop/timeout checks
module ps2_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input logic           CLOCK_50,
  input logic           RESET_N,
  ps2_receiver_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t        state_q;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_prev_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_diff, filt_hit, fall, frame_ok;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [9:0]    shift_q, shift_d;
  logic [7:0]    data_q;
  logic          strobe_q, err_q;
  // filter next-state, falling-edge detect and frame validity of the incoming bit
  always_comb begin
    filt_diff  = clk_sync_q[1] != filt_q;
    filt_hit   = filt_diff && filt_cnt_q == FW'(FILTER_LEN - 1);
    filt_cnt_d = (filt_diff && !filt_hit) ? filt_cnt_q + FW'(1) : '0;
    filt_d     = filt_hit ? ~filt_q : filt_q;
    fall       = filt_prev_q & ~filt_q;
    shift_d    = {dat_sync_q[1], shift_q[9:1]};
    frame_ok   = (^shift_d[8:0]) & shift_d[9];
  end
  // two-flop synchronizers and glitch filter on the PS/2 clock
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.PS2_CLK};
      dat_sync_q  <= {dat_sync_q[0], bus.PS2_DAT};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end
  // frame FSM: start detect, bit shifting, completion check and mid-frame timeout
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      if (state_q == IDLE) begin
        to_cnt_q <= '0;
        if (fall && !dat_sync_q[1]) begin
          state_q   <= RECV;
          bit_cnt_q <= '0;
        end
      end else if (fall) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_q + 4'd1;
        to_cnt_q  <= '0;
        if (bit_cnt_q == 4'd9) begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          strobe_q  <= frame_ok;
          err_q     <= !frame_ok;
          if (frame_ok) data_q <= shift_d[7:0];
        end
      end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        to_cnt_q  <= '0;
        err_q     <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end
  end
  assign bus.ps2_data     = data_q;
  assign bus.ps2_data_clk = strobe_q;
  assign bus.ps2_error    = err_q;
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed and randomized PS/2 frames against a frame-level reference model
module tb_ps2_receiver;
  localparam int FL = 8;
  localparam int TO = 400;
  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  ps2_receiver_if bus();
  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .bus     (bus)
  );
  int n_chk = 0, n_ok = 0;
  int cyc = 0, strobes = 0, errs = 0, stb_cyc = 0, err_cyc = 0, last_fall = 0;
  logic prev_dc = 1'b0;
  logic [7:0] exp_data = 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge CLOCK_50) cyc++;
  always @(negedge CLOCK_50) begin
    if (bus.ps2_data_clk || bus.ps2_error) check("exclusive", {31'd0, bus.ps2_data_clk & bus.ps2_error}, 0);
    if (bus.ps2_data_clk) begin
      check("no_b2b", {31'd0, prev_dc}, 0);
      strobes++;
      stb_cyc = cyc;
    end
    if (bus.ps2_error) begin
      errs++;
      err_cyc = cyc;
    end
    prev_dc = bus.ps2_data_clk;
  end
  task automatic ps2_bit(input logic b, input int hp);
    @(negedge CLOCK_50);
    bus.PS2_DAT = b;
    repeat (2) @(negedge CLOCK_50);
    bus.PS2_CLK = 1'b0;
    last_fall = cyc;
    repeat (hp) @(negedge CLOCK_50);
    bus.PS2_CLK = 1'b1;
    repeat (hp) @(negedge CLOCK_50);
  endtask
  task automatic send_tail(input logic [7:0] b, input logic par, input logic stop, input int hp);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
    ps2_bit(par, hp);
    ps2_bit(stop, hp);
    bus.PS2_DAT = 1'b1;
  endtask
  task automatic expect_frame(input string tag, input logic [7:0] b, input logic par, input logic stop,
                              input int s0, input int e0);
    logic ok;
    ok = ($countones({b, par}) % 2 == 1) && stop;
    if (ok) exp_data = b;
    repeat (20) @(negedge CLOCK_50);
    check({tag, "_strobe"}, strobes - s0, ok ? 1 : 0);
    check({tag, "_err"}, errs - e0, ok ? 0 : 1);
    check({tag, "_data"}, {24'd0, bus.ps2_data}, {24'd0, exp_data});
  endtask
  task automatic frame(input string tag, input logic [7:0] b, input logic par, input logic stop, input int hp);
    int s0, e0;
    s0 = strobes;
    e0 = errs;
    ps2_bit(1'b0, hp);
    send_tail(b, par, stop, hp);
    expect_frame(tag, b, par, stop, s0, e0);
  endtask
  task automatic glitch_then_frame(input string tag, input int w, input logic [7:0] b, input logic par);
    int s0, e0;
    s0 = strobes;
    e0 = errs;
    @(negedge CLOCK_50);
    bus.PS2_DAT = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    bus.PS2_CLK = 1'b0;
    repeat (w) @(negedge CLOCK_50);
    bus.PS2_CLK = 1'b1;
    repeat (30) @(negedge CLOCK_50);
    if (w >= FL) begin
      send_tail(b, par, 1'b1, 20);
    end else begin
      bus.PS2_DAT = 1'b1;
      ps2_bit(1'b0, 20);
      send_tail(b, par, 1'b1, 20);
    end
    expect_frame(tag, b, par, 1'b1, s0, e0);
  endtask
  initial begin
    int s0, e0, hp;
    logic [7:0] b;
    logic par, stop;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (1000) @(negedge CLOCK_50);
    check("rst_data", {24'd0, bus.ps2_data}, 0);
    check("rst_strobes", strobes, 0);
    check("rst_errs", errs, 0);
    frame("f1c", 8'h1C, 1'b0, 1'b1, 20);
    check("latency_ok", (stb_cyc - last_fall >= 11 && stb_cyc - last_fall <= 13) ? 1 : 0, 1);
    frame("rel_f0", 8'hF0, 1'b1, 1'b1, 20);
    frame("rel_1c", 8'h1C, 1'b0, 1'b1, 20);
    frame("par_err", 8'h1C, 1'b1, 1'b1, 20);
    frame("stop_err", 8'h1C, 1'b0, 1'b0, 20);
    s0 = strobes;
    e0 = errs;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 20);
    RESET_N = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    exp_data = 8'h00;
    repeat (50) @(negedge CLOCK_50);
    check("midrst_strobe", strobes - s0, 0);
    check("midrst_err", errs - e0, 0);
    check("midrst_data", {24'd0, bus.ps2_data}, 0);
    frame("after_rst", 8'h1C, 1'b0, 1'b1, 20);
    s0 = strobes;
    e0 = errs;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 20);
    for (int i = 0; i < TO + 200 && errs == e0; i++) @(negedge CLOCK_50);
    check("to_err", errs - e0, 1);
    check("to_strobe", strobes - s0, 0);
    check("to_timing_ok", (err_cyc - last_fall >= TO + 10 && err_cyc - last_fall <= TO + 13) ? 1 : 0, 1);
    frame("after_to", 8'h5A, 1'b1, 1'b1, 20);
    glitch_then_frame("glitch3", 3, 8'h29, 1'b0);
    glitch_then_frame("glitch7", 7, 8'h66, 1'b1);
    glitch_then_frame("pulse8", 8, 8'h3C, 1'b1);
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      hp = $urandom_range(10, 30);
      par = ~^b;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = $urandom_range(0, 7) != 0;
      frame("rand", b, par, stop, hp);
    end
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
- Receive-only PS/2 device-to-host deserializer.
- Samples the raw keyboard PS2_CLK/PS2_DAT lines in the CLOCK_50 domain and checks each 11-bit frame.
- For every valid frame it presents one scan-code byte with a one-cycle strobe.
- Sits directly upstream of the ZX keyboard matrix block: ps2_data / ps2_data_clk drive that block's identically named inputs unchanged.

Parameters:
- FILTER_LEN, 8: consecutive CLOCK_50 cycles a synchronized PS2_CLK level must differ from the filtered level before the filtered level flips.
- TIMEOUT, 50000: CLOCK_50 cycles without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- CLOCK_50      in   1  system clock, 50 MHz
- RESET_N       in   1  synchronous active-low reset
- PS2_CLK       in   1  raw PS/2 clock line, asynchronous, idle high
- PS2_DAT       in   1  raw PS/2 data line, asynchronous, idle high
- ps2_data      out  8  last valid scan-code byte
- ps2_data_clk  out  1  one-cycle strobe, ps2_data newly valid
- ps2_error     out  1  one-cycle strobe, frame rejected (parity/stop/timeout)

Behaviour:
- Interface: one clock, CLOCK_50. Reset is synchronous and active-low, on RESET_N.
- Reset (RESET_N low at posedge):
  - State is IDLE; bit counter, timeout counter and filter counter are 0.
  - Synchronizer flops and filtered clock are 1.
  - ps2_data=8'h00, ps2_data_clk=0, ps2_error=0.
  - Reset mid-frame discards the partial frame with no strobe.
- Synchronization:
  - 2-flop synchronizer on each of PS2_CLK and PS2_DAT.
  - Only the synchronized versions are used downstream.
- Clock filter:
  - The counter increments while synchronized clk != filt_clk, and clears when they are equal.
  - When the counter reaches FILTER_LEN-1, filt_clk toggles and the counter clears.
  - Pulses shorter than FILTER_LEN cycles never reach filt_clk.
- Edge detect: fall = filt_clk_d & ~filt_clk, where filt_clk_d is the previous-cycle filt_clk; fall is high for one cycle.
- Data sampling: data is sampled from synchronized PS2_DAT in the fall cycle.
- FSM, IDLE:
  - fall with dat=0 (start bit): go to RECV, bit_cnt=0, timeout counter=0.
  - fall with dat=1: ignored, stay in IDLE, no error.
- FSM, RECV:
  - Each fall shifts dat into a 10-bit shift register, LSB first: 8 data bits, parity, stop.
  - Each fall increments bit_cnt and clears the timeout counter.
- Frame completion, on the fall that delivers the 10th bit (bit_cnt==9):
  - Valid = (XOR of 8 data bits ^ parity)==1, i.e. odd parity, AND stop==1.
  - Valid: next cycle ps2_data=byte and ps2_data_clk=1 for exactly one cycle.
  - Invalid: next cycle ps2_error=1 for one cycle; ps2_data unchanged.
  - FSM returns to IDLE in the same cycle, so a start bit on the very next fall is accepted.
- Timeout:
  - In RECV the counter increments every cycle without a fall.
  - At TIMEOUT-1 the FSM goes to IDLE and ps2_error pulses one cycle later.
  - In IDLE the counter is held at 0.
  - Counter width is $clog2(TIMEOUT+1).
- Latency: raw PS2_CLK fall to strobe is 2 (sync) + FILTER_LEN (filter) + 1 (edge) + 1 (output reg) cycles, nominally 12.
- Output hold and exclusivity:
  - ps2_data holds its value until the next valid frame.
  - ps2_data_clk and ps2_error are never high in the same cycle.
  - ps2_data_clk is never high on two consecutive cycles.
- Scope: no host-to-device transmit. The block never drives PS2_CLK or PS2_DAT.

Test Plan:
- Reset, lines high: RESET_N low 5 cycles, then idle 1000 cycles -> ps2_data=00, no strobes. Reset asserted after 5 bits of a frame -> no strobe, no error; next full frame decodes.
- Valid frame: 8'h1C at 12.5 kHz PS/2 clock (data LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> exactly one ps2_data_clk pulse, ps2_data=1C, ps2_error never 1, pulse 12 cycles after the stop-bit fall.
- Release sequence back-to-back: F0 (parity 1) then 1C (parity 0), minimum inter-frame gap -> two strobes, ps2_data F0 then 1C.
- Parity error: 1C sent with parity 1 -> one ps2_error pulse, no ps2_data_clk, ps2_data keeps prior value. Stop bit 0 -> same response.
- Timeout: start + 4 data bits, then clock held high 1.2 ms -> ps2_error pulse 50000(+1) cycles after the last fall, FSM back in IDLE. Following 5A frame (parity 1) -> decoded, ps2_data=5A.
- Glitch rejection: 3-cycle low pulse on PS2_CLK with PS2_DAT=0 in IDLE -> no start detected, no strobe. 7-cycle pulse -> ignored. 8-cycle pulse -> counted as an edge.
